// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : Power-up, configuration and lock supervision for the avsdpll
//            macro. Sequences charge-pump / VCO enables, drives the config
//            bus, counts synchronized feedback pulses per reference window
//            and reports LOCK or FAIL.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int T_CP      = 16,
    parameter int T_SETTLE  = 256,
    parameter int WIN       = 64,
    parameter int TOL       = 1,
    parameter int NGOOD     = 4,
    parameter int MAX_WIN   = 16,
    parameter int MAX_RETRY = 3,
    parameter int CNTW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [3:0]      b_cfg,
    input  logic [CNTW-1:0] exp_cnt,
    input  logic            fb_pulse,
    output logic            en_cp,
    output logic            en_vco,
    output logic [3:0]      b,
    output logic            lock,
    output logic            fail,
    output logic            busy,
    output logic [2:0]      state
);

    // Counter widths; the timer is shared by CP_ON, VCO_ON and RETRY.
    localparam int c_tw = $clog2(((T_SETTLE > T_CP) ? T_SETTLE : T_CP) + 1);
    localparam int c_ww = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int c_gw = $clog2(NGOOD + 1);
    localparam int c_nw = $clog2(MAX_WIN + 1);
    localparam int c_rw = $clog2(MAX_RETRY + 2);

    localparam logic [c_tw-1:0] c_tcp_last  = c_tw'(T_CP - 1);
    localparam logic [c_tw-1:0] c_tset_last = c_tw'(T_SETTLE - 1);
    localparam logic [c_ww-1:0] c_wpos_last = c_ww'(WIN - 1);
    localparam logic [c_gw-1:0] c_good_last = c_gw'(NGOOD - 1);
    localparam logic [c_nw-1:0] c_nwin_last = c_nw'(MAX_WIN - 1);
    localparam logic [c_rw-1:0] c_max_retry = c_rw'(MAX_RETRY);
    localparam logic [CNTW:0]   c_tol       = (CNTW + 1)'(TOL);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_CP_ON   = 3'd1,
        S_VCO_ON  = 3'd2,
        S_MEASURE = 3'd3,
        S_LOCKED  = 3'd4,
        S_RETRY   = 3'd5,
        S_FAILED  = 3'd6
    } state_t;

    // Registered enable/status outputs that depend only on the state entered.
    typedef struct packed {
        logic cp;
        logic vco;
        logic busy;
        logic fail;
    } outs_t;

    function automatic outs_t outs_of(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_CP_ON:   begin o.cp = 1'b1; o.busy = 1'b1; end
            S_VCO_ON:  begin o.cp = 1'b1; o.vco = 1'b1; o.busy = 1'b1; end
            S_MEASURE: begin o.cp = 1'b1; o.vco = 1'b1; o.busy = 1'b1; end
            S_LOCKED:  begin o.cp = 1'b1; o.vco = 1'b1; end
            S_RETRY:   o.busy = 1'b1;
            S_FAILED:  o.fail = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    state_t          r_state;
    logic [c_tw-1:0] r_tcnt;
    logic [c_ww-1:0] r_wpos;
    logic [CNTW-1:0] r_fb;
    logic [c_gw-1:0] r_good;
    logic [c_nw-1:0] r_nwin;
    logic [c_rw-1:0] r_retry;

    logic [CNTW:0]   w_fb_sum;
    logic [CNTW-1:0] w_fb_sat;
    logic [CNTW-1:0] w_fb_next;
    logic [CNTW:0]   w_diff;
    logic            w_win_end;
    logic            w_win_good;
    logic            w_lock_now;
    logic            w_reconfig;

    // Feedback count including this cycle's pulse; the first cycle of a
    // window restarts the count so the previous window's total is dropped.
    assign w_fb_sum  = {1'b0, r_fb} + {{CNTW{1'b0}}, fb_pulse};
    assign w_fb_sat  = w_fb_sum[CNTW] ? {CNTW{1'b1}} : w_fb_sum[CNTW-1:0];
    assign w_fb_next = (r_wpos == '0) ? {{(CNTW-1){1'b0}}, fb_pulse} : w_fb_sat;

    // Unsigned absolute difference at CNTW+1 bits, so nothing wraps.
    assign w_diff     = (w_fb_next >= exp_cnt) ? ({1'b0, w_fb_next} - {1'b0, exp_cnt})
                                               : ({1'b0, exp_cnt} - {1'b0, w_fb_next});
    assign w_win_end  = (r_wpos == c_wpos_last);
    assign w_win_good = (w_diff <= c_tol);
    assign w_lock_now = w_win_end && w_win_good && (r_good == c_good_last);
    assign w_reconfig = (b_cfg != b);

    assign state = r_state;

    // Sequencer: state, timers, window bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            en_cp   <= 1'b0;
            en_vco  <= 1'b0;
            busy    <= 1'b0;
            fail    <= 1'b0;
            lock    <= 1'b0;
            b       <= 4'b0000;
            r_tcnt  <= '0;
            r_wpos  <= '0;
            r_fb    <= '0;
            r_good  <= '0;
            r_nwin  <= '0;
            r_retry <= '0;
        end else if (!en) begin
            // Dropping the request wins over everything; B keeps its code.
            r_state <= S_OFF;
            {en_cp, en_vco, busy, fail} <= outs_of(S_OFF);
            lock    <= 1'b0;
            r_tcnt  <= '0;
            r_wpos  <= '0;
            r_fb    <= '0;
            r_good  <= '0;
            r_nwin  <= '0;
            r_retry <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    b       <= b_cfg;
                    r_retry <= '0;
                    r_tcnt  <= '0;
                    r_state <= S_CP_ON;
                    {en_cp, en_vco, busy, fail} <= outs_of(S_CP_ON);
                end

                S_CP_ON: begin
                    if (r_tcnt == c_tcp_last) begin
                        r_tcnt  <= '0;
                        r_state <= S_VCO_ON;
                        {en_cp, en_vco, busy, fail} <= outs_of(S_VCO_ON);
                    end else begin
                        r_tcnt <= r_tcnt + c_tw'(1);
                    end
                end

                S_VCO_ON: begin
                    if (r_tcnt == c_tset_last) begin
                        r_tcnt  <= '0;
                        r_wpos  <= '0;
                        r_fb    <= '0;
                        r_good  <= '0;
                        r_nwin  <= '0;
                        r_state <= S_MEASURE;
                        {en_cp, en_vco, busy, fail} <= outs_of(S_MEASURE);
                    end else begin
                        r_tcnt <= r_tcnt + c_tw'(1);
                    end
                end

                S_MEASURE, S_LOCKED: begin
                    if (w_reconfig) begin
                        // New divider code: settle again before measuring.
                        b       <= b_cfg;
                        lock    <= 1'b0;
                        r_retry <= '0;
                        r_tcnt  <= '0;
                        r_state <= S_VCO_ON;
                        {en_cp, en_vco, busy, fail} <= outs_of(S_VCO_ON);
                    end else begin
                        r_fb   <= w_fb_next;
                        r_wpos <= w_win_end ? '0 : (r_wpos + c_ww'(1));
                        if (w_win_end && (r_state == S_MEASURE)) begin
                            r_good <= w_win_good ? (r_good + c_gw'(1)) : '0;
                            r_nwin <= r_nwin + c_nw'(1);
                            if (w_lock_now) begin
                                lock    <= 1'b1;
                                r_state <= S_LOCKED;
                                {en_cp, en_vco, busy, fail} <= outs_of(S_LOCKED);
                            end else if (r_nwin == c_nwin_last) begin
                                r_tcnt  <= '0;
                                r_state <= S_RETRY;
                                {en_cp, en_vco, busy, fail} <= outs_of(S_RETRY);
                            end
                        end else if (w_win_end && !w_win_good) begin
                            // Lost lock: start a fresh run of good windows.
                            lock    <= 1'b0;
                            r_good  <= '0;
                            r_nwin  <= '0;
                            r_state <= S_MEASURE;
                            {en_cp, en_vco, busy, fail} <= outs_of(S_MEASURE);
                        end
                    end
                end

                S_RETRY: begin
                    if (r_tcnt == c_tcp_last) begin
                        r_tcnt  <= '0;
                        r_retry <= r_retry + c_rw'(1);
                        if (r_retry >= c_max_retry) begin
                            r_state <= S_FAILED;
                            {en_cp, en_vco, busy, fail} <= outs_of(S_FAILED);
                        end else begin
                            r_state <= S_CP_ON;
                            {en_cp, en_vco, busy, fail} <= outs_of(S_CP_ON);
                        end
                    end else begin
                        r_tcnt <= r_tcnt + c_tw'(1);
                    end
                end

                S_FAILED: begin
                    r_state <= S_FAILED;
                end

                default: begin
                    r_state <= S_OFF;
                    {en_cp, en_vco, busy, fail} <= outs_of(S_OFF);
                    lock    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Brief    : Self-checking bench for pll_lock_sequencer. Feedback pulses are
//            scheduled per measurement window from a count plan; expected
//            event times come from the sequencing rules in plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int T_CP      = 16;
    localparam int T_SETTLE  = 256;
    localparam int WIN       = 64;
    localparam int TOL       = 1;
    localparam int NGOOD     = 4;
    localparam int MAX_WIN   = 16;
    localparam int MAX_RETRY = 3;
    localparam int CNTW      = 8;
    localparam int PLAN_MAX  = 64;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            en       = 1'b0;
    logic [3:0]      b_cfg    = 4'h0;
    logic [CNTW-1:0] exp_cnt  = '0;
    logic            fb_pulse = 1'b0;
    logic            en_cp;
    logic            en_vco;
    logic [3:0]      b;
    logic            lock;
    logic            fail;
    logic            busy;
    logic [2:0]      state;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Pulse plan: plan_n[w] pulses in window w, rotated by plan_rot[w].
    int plan_n   [PLAN_MAX];
    int plan_rot [PLAN_MAX];
    int meas_base = 0;
    bit plan_on   = 1'b0;
    int noise_pct = 30;

    pll_lock_sequencer #(
        .T_CP(T_CP), .T_SETTLE(T_SETTLE), .WIN(WIN), .TOL(TOL), .NGOOD(NGOOD),
        .MAX_WIN(MAX_WIN), .MAX_RETRY(MAX_RETRY), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .b_cfg(b_cfg), .exp_cnt(exp_cnt),
        .fb_pulse(fb_pulse), .en_cp(en_cp), .en_vco(en_vco), .b(b),
        .lock(lock), .fail(fail), .busy(busy), .state(state)
    );

    // Reference clock.
    always #5 clk = ~clk;

    // Count rising edges so expected event times can be stated as edge numbers.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Watchdog against a stuck run.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive FB_PULSE for the coming rising edge from the plan (or noise).
    task automatic drive_fb();
        int u;
        int w;
        int p;
        u = edge_n + 1;
        if (plan_on && (u >= meas_base)) begin
            w = (u - meas_base) / WIN;
            p = (u - meas_base) % WIN;
            if (w >= PLAN_MAX) fb_pulse = 1'b0;
            else               fb_pulse = (((p + plan_rot[w]) % WIN) < plan_n[w]);
        end else begin
            fb_pulse = ($urandom_range(0, 99) < noise_pct);
        end
    endtask

    task automatic step_to(input int target);
        while (edge_n < target) begin
            @(negedge clk);
            drive_fb();
        end
    endtask

    task automatic new_plan(input int base);
        meas_base = base;
        for (int w = 0; w < PLAN_MAX; w++) begin
            plan_n[w]   = int'(exp_cnt);
            plan_rot[w] = int'($urandom_range(0, WIN - 1));
        end
    endtask

    function automatic int good_count();
        return int'(exp_cnt) + int'($urandom_range(0, 2)) - 1;
    endfunction

    function automatic bit is_good(input int n);
        int d;
        d = n - int'(exp_cnt);
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    // Window index at which NGOOD consecutive good windows complete.
    function automatic int first_lock(input int from);
        int run;
        run = 0;
        for (int w = from; w < from + MAX_WIN; w++) begin
            if (is_good(plan_n[w])) run++;
            else                    run = 0;
            if (run == NGOOD) return w;
        end
        return -1;
    endfunction

    function automatic int first_bad(input int from);
        for (int w = from; w < PLAN_MAX; w++)
            if (!is_good(plan_n[w])) return w;
        return -1;
    endfunction

    function automatic int win_end_edge(input int w);
        return meas_base + (w + 1) * WIN - 1;
    endfunction

    initial begin
        int e;
        int lw;
        int wb;
        int lw2;
        int s;
        int m;
        int r;
        logic [3:0] nb;
        logic [3:0] nb2;

        // ---- reset state ----
        b_cfg = 4'h5;
        step_to(3);
        check("rst_en_cp", en_cp, 0);
        check("rst_en_vco", en_vco, 0);
        check("rst_b", b, 0);
        check("rst_lock", lock, 0);
        check("rst_fail", fail, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        rst_n = 1'b1;
        step_to(6);
        check("off_idle_state", state, 0);
        check("off_idle_b", b, 0);

        // ---- basic lock: 64 pulses per window ----
        b_cfg   = 4'h8;
        exp_cnt = CNTW'(64);
        e = edge_n + 1;
        new_plan(e + 1 + T_CP + T_SETTLE);
        plan_on = 1'b1;
        en = 1'b1;
        check("t1_cp_pre", en_cp, 0);
        step_to(e);
        check("t1_cp_on", en_cp, 1);
        check("t1_state_cp", state, 1);
        check("t1_busy", busy, 1);
        check("t1_b", b, 8);
        step_to(e + T_CP - 1);
        check("t1_vco_pre", en_vco, 0);
        step_to(e + T_CP);
        check("t1_vco_on", en_vco, 1);
        check("t1_state_vco", state, 2);
        lw = first_lock(0);
        step_to(win_end_edge(lw) - 1);
        check("t1_lock_pre", lock, 0);
        check("t1_state_meas", state, 3);
        step_to(win_end_edge(lw));
        check("t1_lock", lock, 1);
        check("t1_state_locked", state, 4);
        check("t1_busy_locked", busy, 0);
        en = 1'b0;
        step_to(edge_n + 1);
        check("t1_off_state", state, 0);
        check("t1_off_lock", lock, 0);
        check("t1_off_cp", en_cp, 0);
        check("t1_off_b_held", b, 8);

        // ---- good/bad window pattern with random expected count ----
        exp_cnt = CNTW'($urandom_range(8, 56));
        nb = 4'($urandom_range(1, 15));
        b_cfg = nb;
        e = edge_n + 1;
        new_plan(e + 1 + T_CP + T_SETTLE);
        for (int w = 0; w < PLAN_MAX; w++) plan_n[w] = good_count();
        plan_n[2] = int'(exp_cnt) + (($urandom_range(0, 1) == 1) ? 2 : -2);
        plan_n[8] = int'(exp_cnt) - 4;
        en = 1'b1;
        lw = first_lock(0);
        step_to(e);
        check("t2_b_latched", b, 32'(nb));
        step_to(win_end_edge(lw - 1));
        check("t2_no_early_lock", lock, 0);
        step_to(win_end_edge(lw));
        check("t2_lock", lock, 1);
        wb = first_bad(lw + 1);
        step_to(win_end_edge(wb) - 1);
        check("t3_lock_held", lock, 1);
        step_to(win_end_edge(wb));
        check("t3_lock_drop", lock, 0);
        check("t3_state_meas", state, 3);
        lw2 = first_lock(wb + 1);
        step_to(win_end_edge(lw2) - 1);
        check("t3_relock_pre", lock, 0);
        step_to(win_end_edge(lw2));
        check("t3_relock", lock, 1);

        // ---- reconfiguration while locked ----
        step_to(edge_n + int'($urandom_range(5, 40)));
        nb2 = nb ^ 4'($urandom_range(1, 15));
        b_cfg = nb2;
        e = edge_n + 1;
        new_plan(e + 1 + T_SETTLE);
        step_to(e);
        check("t4_b_new", b, 32'(nb2));
        check("t4_lock_clr", lock, 0);
        check("t4_vco_held", en_vco, 1);
        check("t4_state_vco", state, 2);
        lw = first_lock(0);
        step_to(win_end_edge(lw) - 1);
        check("t4_relock_pre", lock, 0);
        step_to(win_end_edge(lw));
        check("t4_relock", lock, 1);

        // ---- no valid feedback: retries then FAIL ----
        en = 1'b0;
        step_to(edge_n + 1);
        check("t5_off", state, 0);
        exp_cnt = CNTW'(64);
        plan_on = 1'b0;
        en = 1'b1;
        s = edge_n + 1;
        for (int a = 1; a <= MAX_RETRY + 1; a++) begin
            m = s + 1 + T_CP + T_SETTLE;
            r = m + MAX_WIN * WIN - 1;
            step_to(r - 1);
            check("t5_meas", state, 3);
            step_to(r);
            check("t5_retry_state", state, 5);
            check("t5_retry_cp", en_cp, 0);
            check("t5_retry_vco", en_vco, 0);
            s = r + T_CP;
            step_to(s - 1);
            check("t5_retry_hold", state, 5);
            step_to(s);
            if (a <= MAX_RETRY) begin
                check("t5_cp_again", state, 1);
                check("t5_cp_again_en", en_cp, 1);
            end else begin
                check("t5_failed_state", state, 6);
                check("t5_fail", fail, 1);
                check("t5_fail_busy", busy, 0);
            end
        end
        step_to(edge_n + 20);
        check("t5_fail_sticky", fail, 1);
        en = 1'b0;
        step_to(edge_n + 1);
        check("t5_fail_clr", fail, 0);
        check("t5_fail_off", state, 0);

        // ---- asynchronous reset mid-measurement ----
        nb = 4'($urandom_range(0, 15));
        b_cfg = nb;
        en = 1'b1;
        s = edge_n + 1;
        step_to(s + 1 + T_CP + T_SETTLE + int'($urandom_range(10, 100)));
        check("t6_in_meas", state, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_cp", en_cp, 0);
        check("t6_async_vco", en_vco, 0);
        check("t6_async_b", b, 0);
        check("t6_async_state", state, 0);
        check("t6_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        e = edge_n + 1;
        step_to(e);
        check("t6_restart_state", state, 1);
        check("t6_restart_b", b, 32'(nb));
        step_to(e + T_CP);
        check("t6_restart_vco", en_vco, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
